// File: rtl/cnn_pkg.sv
// ---------------------------------------------------------------------------
// cnn_pkg
// Shared definitions for the convolution engine result read path.
//   CNN_DATA_W  : default result word width (engine produces 32-bit sums)
//   CNN_ADDR_W  : default output-memory address width (7-bit addressing)
//   CNN_FIFO_D  : skid buffer depth (fixed at 2)
//   rd_state_t  : readout FSM state encoding
// ---------------------------------------------------------------------------
package cnn_pkg;

    localparam int CNN_DATA_W = 32;
    localparam int CNN_ADDR_W = 7;
    localparam int CNN_FIFO_D = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_FLUSH  = 2'd2,
        ST_FINISH = 2'd3
    } rd_state_t;

endpackage

// File: rtl/cnn_skid_fifo.sv
// ---------------------------------------------------------------------------
// cnn_skid_fifo
// Two-entry synchronous FIFO that absorbs the output memory's one-cycle read
// latency while the downstream stream is stalled. Entry 0 is the head and
// drives the stream outputs directly, so a stalled head never changes.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   i_push     : write i_data/i_last this cycle (dropped if full and no pop)
//   i_pop      : remove the head this cycle (ignored when empty)
//   i_data     : word to write
//   i_last     : last-word sideband travelling with i_data
//   o_occ      : number of stored entries (0..2)
//   o_valid    : head entry present
//   o_data     : head word
//   o_last     : head last flag, qualified by o_valid
// ---------------------------------------------------------------------------
module cnn_skid_fifo
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_last,
    output logic [1:0]        o_occ,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic              o_last
);

    logic [DATA_W-1:0] r_data0;
    logic [DATA_W-1:0] r_data1;
    logic              r_last0;
    logic              r_last1;
    logic [1:0]        r_occ;

    logic              w_pop;
    logic              w_push;

    assign w_pop  = i_pop & (r_occ != 2'd0);
    assign w_push = i_push & ((r_occ != 2'd2) | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_data0 <= '0;
            r_data1 <= '0;
            r_last0 <= 1'b0;
            r_last1 <= 1'b0;
            r_occ   <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_data0 <= i_data;
                        r_last0 <= i_last;
                    end else begin
                        r_data1 <= i_data;
                        r_last1 <= i_last;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_data0 <= r_data1;
                    r_last0 <= r_last1;
                    r_occ   <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; the new word lands behind
                    // whatever remains after the head leaves.
                    if (r_occ == 2'd1) begin
                        r_data0 <= i_data;
                        r_last0 <= i_last;
                    end else begin
                        r_data0 <= r_data1;
                        r_last0 <= r_last1;
                        r_data1 <= i_data;
                        r_last1 <= i_last;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_occ   = r_occ;
    assign o_valid = (r_occ != 2'd0);
    assign o_data  = r_data0;
    // The head flag may be stale after the last pop; never show it without
    // a valid word.
    assign o_last  = r_last0 & o_valid;

endmodule

// File: rtl/cnn_result_reader.sv
// ---------------------------------------------------------------------------
// cnn_result_reader
// Read-side counterpart of the convolution engine's result write path. After
// the engine pulses done_in, reads len words from the output memory starting
// at base_addr (address wraps modulo 2^ADDR_W) and streams them out in
// address order.
//
// Stream handshake (valid/ready): a word transfers on every cycle where
// out_valid and out_ready are both high. Once out_valid is raised it stays
// high, with out_data/out_last unchanged, until that transfer happens;
// out_valid never depends combinationally on out_ready.
//
// Optional build macro: CNN_READER_CHECKSUM_EN adds the checksum output, the
// modulo-2^DATA_W sum of all words transferred in the current readout.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   done_in       : engine completion strobe, accepted only when idle
//   base_addr     : first word address, sampled on accepted trigger
//   len           : word count 0..2^ADDR_W, sampled on accepted trigger
//   mem_rd_en     : memory read request
//   mem_addr      : memory read address
//   mem_rd_data   : read data, valid the cycle after mem_rd_en
//   out_valid     : stream word valid
//   out_data      : stream word
//   out_last      : high with the final word of the readout
//   out_ready     : downstream accept
//   busy          : high from accepted trigger until rd_done
//   rd_done       : one-cycle pulse after the final transfer
//   checksum      : (macro only) running sum of transferred words
//   dbg_state     : current FSM state
// ---------------------------------------------------------------------------
module cnn_result_reader
    import cnn_pkg::*;
#(
    parameter int DATA_W = CNN_DATA_W,
    parameter int ADDR_W = CNN_ADDR_W,
    parameter int FIFO_D = CNN_FIFO_D
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              done_in,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy,
    output logic              rd_done,
`ifdef CNN_READER_CHECKSUM_EN
    output logic [DATA_W-1:0] checksum,
`endif
    output rd_state_t         dbg_state
);

    localparam logic [2:0] FIFO_LIMIT = 3'(FIFO_D);

    rd_state_t         r_state;
    rd_state_t         w_next_state;

    logic [ADDR_W:0]   r_len;
    logic [ADDR_W:0]   r_issue_cnt;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic              r_inflight;
    logic              r_inflight_last;

    logic [1:0]        w_occ;
    logic              w_fifo_valid;
    logic [DATA_W-1:0] w_fifo_data;
    logic              w_fifo_last;

    logic              w_pop;
    logic              w_last_pop;
    logic              w_room;
    logic              w_issue;
    logic              w_issue_last;
    logic              w_trigger;

    // ---------------------------------------------------------------------
    // Read issue control
    // ---------------------------------------------------------------------
    assign w_pop      = w_fifo_valid & out_ready;
    assign w_last_pop = w_pop & w_fifo_last;
    assign w_trigger  = (r_state == ST_IDLE) & done_in;

    // Every issued read owns a FIFO slot: stored words plus the read still
    // in flight, minus the word leaving this cycle, must leave space.
    assign w_room = ({1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop})
                    < FIFO_LIMIT;

    assign w_issue      = (r_state == ST_STREAM) & (r_issue_cnt < r_len) & w_room;
    assign w_issue_last = w_issue & ((r_issue_cnt + (ADDR_W+1)'(1)) == r_len);

    // ---------------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FSM: next state and outputs
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        rd_done      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (done_in) begin
                    // A zero-length readout spends one cycle in FLUSH, which
                    // completes at once, so busy is seen for one cycle and
                    // rd_done follows two cycles after the trigger.
                    if (len == '0) begin
                        w_next_state = ST_FLUSH;
                    end else begin
                        w_next_state = ST_STREAM;
                    end
                end
            end
            ST_STREAM: begin
                busy = 1'b1;
                if (w_issue_last) begin
                    w_next_state = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                busy = 1'b1;
                if ((r_len == '0) || (!r_inflight && w_last_pop)) begin
                    w_next_state = ST_FINISH;
                end
            end
            ST_FINISH: begin
                rd_done      = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Readout counters and read pipeline
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_len           <= '0;
            r_issue_cnt     <= '0;
            r_rd_ptr        <= '0;
            r_inflight      <= 1'b0;
            r_inflight_last <= 1'b0;
        end else begin
            r_inflight      <= w_issue;
            r_inflight_last <= w_issue_last;
            if (w_trigger) begin
                r_len       <= len;
                r_rd_ptr    <= base_addr;
                r_issue_cnt <= '0;
            end else if (w_issue) begin
                // Natural overflow wraps the address at the top of memory.
                r_rd_ptr    <= r_rd_ptr + ADDR_W'(1);
                r_issue_cnt <= r_issue_cnt + (ADDR_W+1)'(1);
            end
        end
    end

    assign mem_rd_en = w_issue;
    assign mem_addr  = r_rd_ptr;

    // ---------------------------------------------------------------------
    // Skid buffer: read data arrives the cycle after the request
    // ---------------------------------------------------------------------
    cnn_skid_fifo #(
        .DATA_W (DATA_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (r_inflight),
        .i_pop   (out_ready),
        .i_data  (mem_rd_data),
        .i_last  (r_inflight_last),
        .o_occ   (w_occ),
        .o_valid (w_fifo_valid),
        .o_data  (w_fifo_data),
        .o_last  (w_fifo_last)
    );

    assign out_valid = w_fifo_valid;
    assign out_data  = w_fifo_data;
    assign out_last  = w_fifo_last;
    assign dbg_state = r_state;

`ifdef CNN_READER_CHECKSUM_EN
    // ---------------------------------------------------------------------
    // Checksum of transferred words; holds after rd_done until next trigger
    // ---------------------------------------------------------------------
    logic [DATA_W-1:0] r_checksum;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_checksum <= '0;
        end else if (w_trigger) begin
            r_checksum <= '0;
        end else if (w_pop) begin
            r_checksum <= r_checksum + w_fifo_data;
        end
    end

    assign checksum = r_checksum;
`endif

endmodule

// File: tb/tb_cnn_result_reader.sv
// ---------------------------------------------------------------------------
// tb_cnn_result_reader
// Self-checking bench for cnn_result_reader. The expected word stream and
// read address sequence of each readout are computed from the memory
// contents, base address and length, and queued when the readout starts;
// a monitor pops and compares on every transfer and every memory read.
// ---------------------------------------------------------------------------
module tb_cnn_result_reader;
  import cnn_pkg::*;

  localparam int DATA_W = CNN_DATA_W;
  localparam int ADDR_W = CNN_ADDR_W;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------------------------------------------------------------
  // Clock, reset and DUT signals
  // ---------------------------------------------------------------------
  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              done_in = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W:0]   len = '0;
  logic              mem_rd_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_last;
  logic              out_ready = 1'b0;
  logic              busy;
  logic              rd_done;
  rd_state_t         dbg_state;
`ifdef CNN_READER_CHECKSUM_EN
  logic [DATA_W-1:0] checksum;
`endif

  always #5 clk = ~clk;

  cnn_result_reader dut (
    .clk         (clk),
    .rst         (rst),
    .done_in     (done_in),
    .base_addr   (base_addr),
    .len         (len),
    .mem_rd_en   (mem_rd_en),
    .mem_addr    (mem_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_last    (out_last),
    .out_ready   (out_ready),
    .busy        (busy),
    .rd_done     (rd_done),
`ifdef CNN_READER_CHECKSUM_EN
    .checksum    (checksum),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state and reference model
  // ---------------------------------------------------------------------
  int                n_checks = 0;
  int                n_errors = 0;
  logic [DATA_W:0]   exp_q[$];       // {last, data}
  logic [ADDR_W-1:0] exp_addr_q[$];
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] exp_sum = '0;
  int                rd_done_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_bit(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Expected stream: words mem[(base+k) mod DEPTH] for k = 0..n-1, the last
  // one flagged, and the checksum as their plain sum.
  task automatic push_expect(input int base, input int n);
    logic [ADDR_W-1:0] ai;
    logic              lastbit;
    exp_sum = '0;
    for (int k = 0; k < n; k++) begin
      ai      = ADDR_W'((base + k) % DEPTH);
      lastbit = (k == n - 1);
      exp_q.push_back({lastbit, mem[ai]});
      exp_addr_q.push_back(ai);
      exp_sum = exp_sum + mem[ai];
    end
  endtask

  task automatic fill_mem_linear();
    for (int a = 0; a < DEPTH; a++) mem[a] = DATA_W'(a * 3);
  endtask

  task automatic fill_mem_random();
    for (int a = 0; a < DEPTH; a++) mem[a] = $urandom;
  endtask

  function automatic logic pick_ready(input int mode, input int c);
    int m;
    m = (c - 1) % 6;
    if (mode == 0) return 1'b1;
    if (mode == 1) return (m == 0) || (m == 3) || (m == 5);
    return 1'($urandom_range(0, 1));
  endfunction

  // ---------------------------------------------------------------------
  // Memory model: data valid the cycle after the request
  // ---------------------------------------------------------------------
  initial begin
    forever begin
      @(posedge clk);
      if (mem_rd_en) mem_rd_data <= mem[mem_addr];
    end
  end

  // ---------------------------------------------------------------------
  // Monitor: transfers, stall stability, read addresses, occupancy
  // ---------------------------------------------------------------------
  initial begin
    logic            prev_stall;
    logic [DATA_W:0] prev_word;
    logic [DATA_W:0] w;
    logic [ADDR_W-1:0] a;
    prev_stall = 1'b0;
    prev_word  = '0;
    forever begin
      @(negedge clk);
      n_checks++;
      if (dut.u_fifo.o_occ > 2'd2) begin
        n_errors++;
        $display("FAIL occ_bound: got %0d, expected <= 2 (t=%0t)", dut.u_fifo.o_occ, $time);
      end
      if (prev_stall) begin
        chk("stall_hold", 64'({out_valid, out_last, out_data}), 64'({1'b1, prev_word}));
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("unexpected_word");
        end else begin
          w = exp_q.pop_front();
          chk("word", 64'({out_last, out_data}), 64'(w));
        end
      end
      if (mem_rd_en) begin
        if (exp_addr_q.size() == 0) begin
          fail_now("unexpected_read");
        end else begin
          a = exp_addr_q.pop_front();
          chk("rd_addr", 64'(mem_addr), 64'(a));
        end
      end
      if (rd_done) rd_done_cnt++;
      prev_stall = out_valid && !out_ready && !rst;
      prev_word  = {out_last, out_data};
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  task automatic trigger(input int base, input int n);
    @(posedge clk); #1;
    done_in   = 1'b1;
    base_addr = ADDR_W'(base);
    len       = (ADDR_W+1)'(n);
    out_ready = 1'b1;
    push_expect(base, n);
  endtask

  // One complete readout. Cycle 0 is the trigger cycle. With timed set,
  // the cycle-exact profile is checked (out_ready must be mode 0).
  // With poke set, done_in is raised again in the rd_done cycle.
  task automatic run_readout(input int base, input int n, input int mode,
                             input bit timed, input bit poke);
    int done_cyc;
    int budget;
    int start_done;
    bit seen;
    done_cyc   = (n == 0) ? 2 : n + 3;
    budget     = 8 * n + 40;
    start_done = rd_done_cnt;
    seen       = 1'b0;
    trigger(base, n);
    for (int c = 1; c <= budget && !seen; c++) begin
      @(posedge clk); #1;
      done_in   = poke && (c == done_cyc);
      out_ready = pick_ready(mode, c);
      @(negedge clk);
      if (timed) begin
        chk_bit("t_rd_en",     mem_rd_en, (c >= 1) && (c <= n));
        chk_bit("t_out_valid", out_valid, (c >= 3) && (c <= n + 2));
        chk_bit("t_out_last",  out_last,  (n > 0) && (c == n + 2));
        chk_bit("t_rd_done",   rd_done,   c == done_cyc);
        chk_bit("t_busy",      busy,      c < done_cyc);
      end
      if (rd_done) begin
        seen = 1'b1;
`ifdef CNN_READER_CHECKSUM_EN
        chk("checksum", 64'(checksum), 64'(exp_sum));
`endif
      end
    end
    if (!seen) fail_now("rd_done_timeout");
    chk("words_left", 64'(exp_q.size()), 64'd0);
    chk("reads_left", 64'(exp_addr_q.size()), 64'd0);
    @(posedge clk); #1;
    done_in = 1'b0;
    @(negedge clk);
    chk_bit("done_one_cycle", rd_done, 1'b0);
    chk_bit("busy_after", busy, 1'b0);
    chk_bit("no_read_after", mem_rd_en, 1'b0);
    chk("done_count", 64'(rd_done_cnt - start_done), 64'd1);
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin
    int start_done;
    bit seen;

    // Reset and reset-state checks
    fill_mem_linear();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk_bit("rst_rd_en", mem_rd_en, 1'b0);
    chk_bit("rst_out_valid", out_valid, 1'b0);
    chk_bit("rst_out_last", out_last, 1'b0);
    chk_bit("rst_busy", busy, 1'b0);
    chk_bit("rst_rd_done", rd_done, 1'b0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_mem_addr", 64'(mem_addr), 64'd0);
    chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));

    // base 10, len 4, ready held high; done_in poked during FINISH
    run_readout(10, 4, 0, 1'b1, 1'b1);
    // same, with out_ready toggling 1,0,0,1,0,1,...
    run_readout(10, 4, 1, 1'b0, 1'b0);
    // address wrap 126,127,0,1
    run_readout(126, 4, 0, 1'b1, 1'b0);
    // zero length
    run_readout(5, 0, 0, 1'b1, 1'b0);
    // single word and full memory
    run_readout(77, 1, 0, 1'b1, 1'b0);
    run_readout(0, DEPTH, 0, 1'b1, 1'b0);

    // done_in re-pulsed at cycle 2 of an active readout is ignored
    start_done = rd_done_cnt;
    seen       = 1'b0;
    trigger(10, 4);
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(posedge clk); #1;
      done_in = (c == 2);
      if (c == 2) begin
        base_addr = ADDR_W'(50);
        len       = (ADDR_W+1)'(3);
      end
      @(negedge clk);
      if (rd_done) seen = 1'b1;
    end
    if (!seen) fail_now("repulse_timeout");
    chk("repulse_words_left", 64'(exp_q.size()), 64'd0);
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      done_in = 1'b0;
      @(negedge clk);
      chk_bit("repulse_quiet_valid", out_valid, 1'b0);
      chk_bit("repulse_quiet_busy", busy, 1'b0);
    end
    chk("repulse_done_count", 64'(rd_done_cnt - start_done), 64'd1);

    // Reset in cycle 4 of a fresh readout aborts it
    start_done = rd_done_cnt;
    trigger(20, 4);
    for (int c = 1; c <= 4; c++) begin
      @(posedge clk); #1;
      done_in = 1'b0;
      rst     = (c == 4);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    exp_addr_q.delete();
    @(negedge clk);
    chk_bit("abort_rd_en", mem_rd_en, 1'b0);
    chk_bit("abort_out_valid", out_valid, 1'b0);
    chk_bit("abort_out_last", out_last, 1'b0);
    chk_bit("abort_busy", busy, 1'b0);
    chk_bit("abort_rd_done", rd_done, 1'b0);
    chk("abort_out_data", 64'(out_data), 64'd0);
    repeat (12) @(negedge clk);
    chk("abort_no_done", 64'(rd_done_cnt - start_done), 64'd0);

    // Randomised readouts: random memory, base, length and backpressure
    for (int r = 0; r < 12; r++) begin
      int n;
      fill_mem_random();
      case (r % 4)
        0:       n = $urandom_range(1, 6);
        1:       n = $urandom_range(1, DEPTH);
        2:       n = (r == 2) ? DEPTH : $urandom_range(0, 3);
        default: n = $urandom_range(7, 40);
      endcase
      run_readout($urandom_range(0, DEPTH - 1), n, 2, 1'b0, 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
